motor_speed_ctrl: RTL and testbench



---
 rtl/motor_ctrl_pkg.sv | 15 +
 rtl/pwm_gen.sv | 38 +++
 rtl/motor_speed_ctrl.sv | 155 +++++++++++++++
 tb/tb_motor_speed_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/motor_ctrl_pkg.sv
// Shared types and constants for the DC motor speed controller.
package motor_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, CAPTURE, CALC, COMMIT} ctrl_state_t;

  localparam int unsigned GAIN_W            = 8;
  localparam int unsigned GAIN_FRAC_BITS    = 4;
  localparam int unsigned DEFAULT_ACC_WIDTH = 24;

  // Symmetric integrator bound: +/-(2^(acc_width-1) - 1)
  function automatic longint acc_limit(input int unsigned acc_width);
    return (longint'(1) << (acc_width - 1)) - longint'(1);
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// Glitch-free PWM: duty is shadowed and only taken at a period boundary.
module pwm_gen #(
  parameter int unsigned DUTY_WIDTH = 8,
  parameter int unsigned PWM_PRESC  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DUTY_WIDTH-1:0] duty,
  output logic                  pwm_out
);

  localparam int unsigned PRESC_W = (PWM_PRESC > 1) ? $clog2(PWM_PRESC) : 1;

  logic [PRESC_W-1:0]    presc_cnt;
  logic [DUTY_WIDTH-1:0] pwm_cnt;
  logic [DUTY_WIDTH-1:0] duty_act;
  logic                  presc_wrap_c;

  assign presc_wrap_c = (presc_cnt == PRESC_W'(PWM_PRESC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
      duty_act  <= '0;
      pwm_out   <= 1'b0;
    end else begin
      presc_cnt <= presc_wrap_c ? '0 : presc_cnt + PRESC_W'(1);
      if (presc_wrap_c) pwm_cnt <= pwm_cnt + DUTY_WIDTH'(1);
      // New duty only when the counter rolls over to 0
      if (!enable)                          duty_act <= '0;
      else if (presc_wrap_c && &pwm_cnt)    duty_act <= duty;
      pwm_out <= enable && (pwm_cnt < duty_act);
    end
  end

endmodule

// File: rtl/motor_speed_ctrl.sv
// Closed-loop PI speed regulator: periodic update of duty from setpoint/freq,
// followed by a glitch-free PWM driver for the H-bridge enable.
module motor_speed_ctrl
  import motor_ctrl_pkg::*;
#(
  parameter int unsigned FREQ_WIDTH  = 8,
  parameter int unsigned DUTY_WIDTH  = 8,
  parameter int unsigned ACC_WIDTH   = DEFAULT_ACC_WIDTH,
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned UPDATE_HZ   = 100,
  parameter int unsigned PWM_FREQ_HZ = 20_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [FREQ_WIDTH-1:0] setpoint,
  input  logic [FREQ_WIDTH-1:0] freq,
  input  logic [GAIN_W-1:0]     kp,
  input  logic [GAIN_W-1:0]     ki,
  output logic [DUTY_WIDTH-1:0] duty,
  output logic                  pwm_out,
  output logic                  saturated,
  output logic                  update
);

  localparam int unsigned TICK_DIV  = CLK_FREQ_HZ / UPDATE_HZ;
  localparam int unsigned TICK_W    = $clog2(TICK_DIV);
  localparam int unsigned PWM_RAW   = CLK_FREQ_HZ / (PWM_FREQ_HZ * (2 ** DUTY_WIDTH));
  localparam int unsigned PWM_PRESC = (PWM_RAW > 0) ? PWM_RAW : 1;
  localparam int unsigned ERR_W     = FREQ_WIDTH + 1;
  localparam int unsigned PROD_W    = FREQ_WIDTH + 10;
  localparam int unsigned SUM_W     = ACC_WIDTH + 1;

  localparam logic signed [SUM_W-1:0] ACC_MAX  = SUM_W'(acc_limit(ACC_WIDTH));
  localparam logic signed [SUM_W-1:0] ACC_MIN  = -ACC_MAX;
  localparam logic signed [SUM_W-1:0] DUTY_MAX = SUM_W'((2 ** DUTY_WIDTH) - 1);

  ctrl_state_t state, state_nx;

  logic [TICK_W-1:0]        tick_cnt;
  logic                     tick;
  logic signed [ERR_W-1:0]  err_q;
  logic [GAIN_W-1:0]        kp_q, ki_q;
  logic                     sp_zero_q;
  logic signed [ACC_WIDTH-1:0] integ;
  logic signed [SUM_W-1:0]  i_next_q, sum_q;

  logic signed [PROD_W-1:0] p_c, ki_term_c;
  logic signed [SUM_W-1:0]  i_raw_c, i_next_c, sum_c;
  logic                     sat_hi_c, sat_lo_c, err_pos_c, err_neg_c;

  assign tick = enable && (tick_cnt == TICK_W'(TICK_DIV - 1));

  // Update-rate divider, parked at 0 while stopped
  always_ff @(posedge clk) begin
    if (reset || !enable) tick_cnt <= '0;
    else if (tick)        tick_cnt <= '0;
    else                  tick_cnt <= tick_cnt + TICK_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (tick) state_nx = CAPTURE;
      CAPTURE: state_nx = CALC;
      CALC:    state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (!enable) state_nx = IDLE;
  end

  // PI arithmetic on the latched operands
  always_comb begin
    p_c       = PROD_W'($signed({1'b0, kp_q})) * PROD_W'(err_q);
    ki_term_c = PROD_W'($signed({1'b0, ki_q})) * PROD_W'(err_q);
    i_raw_c   = SUM_W'(integ) + SUM_W'(ki_term_c);
    if (i_raw_c > ACC_MAX)      i_next_c = ACC_MAX;
    else if (i_raw_c < ACC_MIN) i_next_c = ACC_MIN;
    else                        i_next_c = i_raw_c;
    sum_c = (SUM_W'(p_c) + i_next_c) >>> GAIN_FRAC_BITS;
  end

  assign sat_lo_c  = sum_q[SUM_W-1];
  assign sat_hi_c  = (sum_q > DUTY_MAX);
  assign err_neg_c = err_q[ERR_W-1];
  assign err_pos_c = !err_q[ERR_W-1] && (err_q != '0);

  // Datapath registers; each state's work lands on the edge that enters it
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q     <= '0;
      kp_q      <= '0;
      ki_q      <= '0;
      sp_zero_q <= 1'b0;
      i_next_q  <= '0;
      sum_q     <= '0;
      integ     <= '0;
      duty      <= '0;
      saturated <= 1'b0;
      update    <= 1'b0;
    end else if (!enable) begin
      integ     <= '0;
      duty      <= '0;
      saturated <= 1'b0;
      update    <= 1'b0;
    end else begin
      update <= 1'b0;
      case (state)
        IDLE: if (tick) begin
          err_q     <= $signed({1'b0, setpoint}) - $signed({1'b0, freq});
          kp_q      <= kp;
          ki_q      <= ki;
          sp_zero_q <= (setpoint == '0);
        end
        CAPTURE: begin
          i_next_q <= i_next_c;
          sum_q    <= sum_c;
        end
        CALC: begin
          update <= 1'b1;
          if (sp_zero_q) begin
            duty      <= '0;
            integ     <= '0;
            saturated <= 1'b0;
          end else begin
            duty      <= sat_hi_c ? '1 : (sat_lo_c ? '0 : sum_q[DUTY_WIDTH-1:0]);
            saturated <= sat_hi_c | sat_lo_c;
            // Anti-windup: freeze the integrator while pushing further into a clamp
            if (!(sat_hi_c && err_pos_c) && !(sat_lo_c && err_neg_c))
              integ <= i_next_q[ACC_WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  pwm_gen #(
    .DUTY_WIDTH (DUTY_WIDTH),
    .PWM_PRESC  (PWM_PRESC)
  ) u_pwm_gen (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .duty    (duty),
    .pwm_out (pwm_out)
  );

endmodule

// File: tb/tb_motor_speed_ctrl.sv
// Directed bench for motor_speed_ctrl with hand-computed expectations.
module tb_motor_speed_ctrl;
  import motor_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset, enable;
  logic [7:0] setpoint, freq, kp, ki;
  logic [7:0] duty;
  logic       pwm_out, saturated, update;

  int checks   = 0;
  int failures = 0;
  int hi_run   = 0;
  int lat, c, w;
  logic hi_at;

  always #5 clk = ~clk;

  motor_speed_ctrl #(
    .FREQ_WIDTH  (8),
    .DUTY_WIDTH  (8),
    .ACC_WIDTH   (24),
    .CLK_FREQ_HZ (1000),
    .UPDATE_HZ   (10),
    .PWM_FREQ_HZ (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .setpoint  (setpoint),
    .freq      (freq),
    .kp        (kp),
    .ki        (ki),
    .duty      (duty),
    .pwm_out   (pwm_out),
    .saturated (saturated),
    .update    (update)
  );

  // Length of the current run of high samples on pwm_out
  always @(negedge clk) hi_run <= (pwm_out === 1'b1) ? hi_run + 1 : 0;

  task automatic check_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_update(output int n);
    n = -1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
      if (update) begin n = i; break; end
    end
  endtask

  task automatic wait_tick(output int n);
    n = -1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
      if (dut.tick) begin n = i; break; end
    end
  endtask

  task automatic count_high(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (pwm_out) cnt++;
    end
  endtask

  task automatic pulse_width(output int width);
    width = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (pwm_out) break;
    end
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!pwm_out) begin width = hi_run; break; end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b1;
    setpoint = 8'd100; freq = 8'd60; kp = 8'd16; ki = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_duty", duty, 0);
    check_eq("rst_pwm", pwm_out, 0);
    check_eq("rst_sat", saturated, 0);
    check_eq("rst_update", update, 0);
    check_eq("rst_integ", dut.integ, 0);

    // P-only: err=40 -> duty=40, first commit 102 edges after release
    @(negedge clk) reset = 1'b0;
    wait_update(lat);
    check_eq("p_first_latency", lat, 102);
    check_eq("p_duty", duty, 40);
    check_eq("p_sat", saturated, 0);
    @(posedge clk); #1;
    check_eq("update_one_cycle", update, 0);

    // Reset while the next update sits in CALC
    repeat (98) @(posedge clk);
    #1;
    check_eq("state_calc", dut.state, CALC);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst_duty", duty, 0);
    check_eq("midrst_update", update, 0);
    check_eq("midrst_sat", saturated, 0);
    check_eq("midrst_pwm", pwm_out, 0);

    // First tick 100 cycles after release; operands frozen after capture
    @(negedge clk) reset = 1'b0;
    wait_tick(lat);
    check_eq("tick_after_rst", lat, 99);
    @(posedge clk); #1;
    lat = 1;
    @(negedge clk);
    freq = 8'd0; kp = 8'd0; ki = 8'd255;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      lat++;
      if (update) break;
    end
    check_eq("tick_to_update", lat, 3);
    check_eq("frozen_duty", duty, 40);
    check_eq("frozen_integ", dut.integ, 0);

    // I-only: err=10, ki=1.0 -> integ 160/320/480, duty 10/20/30
    @(negedge clk);
    kp = 8'd0; ki = 8'd16; setpoint = 8'd100; freq = 8'd90;
    for (int k = 1; k <= 3; k++) begin
      wait_update(lat);
      check_eq("i_period", lat, 100);
      check_eq("i_duty", duty, 10 * k);
      check_eq("i_integ", dut.integ, 160 * k);
      check_eq("i_sat", saturated, 0);
    end

    // Stop clears the integrator and duty
    @(negedge clk) enable = 1'b0;
    @(posedge clk); #1;
    check_eq("stop_integ", dut.integ, 0);
    check_eq("stop_duty", duty, 0);
    @(negedge clk);
    kp = 8'd128; ki = 8'd16; setpoint = 8'd255; freq = 8'd0;
    enable = 1'b1;

    // High clamp with anti-windup holding integ at 0
    for (int k = 0; k < 5; k++) begin
      wait_update(lat);
      check_eq("hi_latency", lat, (k == 0) ? 102 : 100);
      check_eq("hi_duty", duty, 255);
      check_eq("hi_sat", saturated, 1);
      check_eq("hi_integ", dut.integ, 0);
    end
    @(negedge clk);
    setpoint = 8'd50; freq = 8'd80; kp = 8'd16;
    wait_update(lat);
    check_eq("lo_duty", duty, 0);
    check_eq("lo_sat", saturated, 1);
    check_eq("lo_integ", dut.integ, 0);

    // PWM width 64 of 256
    @(negedge clk);
    kp = 8'd16; ki = 8'd0; setpoint = 8'd100; freq = 8'd36;
    wait_update(lat);
    check_eq("pwm64_duty", duty, 64);
    check_eq("pwm64_sat", saturated, 0);
    repeat (600) @(posedge clk);
    count_high(256, c);
    check_eq("pwm64_window", c, 64);

    // Duty change mid-period: pulse in flight keeps its old width
    wait_update(lat);
    @(negedge clk);
    setpoint = 8'd200; freq = 8'd8;
    wait_update(lat);
    check_eq("pwm192_duty", duty, 192);
    hi_at = pwm_out;
    pulse_width(w);
    check_eq("pwm_first_pulse", w, hi_at ? 64 : 192);
    pulse_width(w);
    check_eq("pwm_next_pulse", w, 192);
    count_high(256, c);
    check_eq("pwm192_window", c, 192);

    // Stop mid-update: no pulse, everything cleared next cycle
    wait_update(lat);
    @(negedge clk);
    kp = 8'd0; ki = 8'd16; setpoint = 8'd100; freq = 8'd90;
    wait_update(lat);
    check_eq("pre_stop_integ", dut.integ, 160);
    repeat (99) @(posedge clk);
    #1;
    check_eq("stop_state_calc", dut.state, CALC);
    @(negedge clk) enable = 1'b0;
    @(posedge clk); #1;
    check_eq("stopcalc_update", update, 0);
    check_eq("stopcalc_duty", duty, 0);
    check_eq("stopcalc_integ", dut.integ, 0);
    check_eq("stopcalc_pwm", pwm_out, 0);
    c = 0;
    repeat (150) begin
      @(posedge clk); #1;
      if (update) c++;
    end
    check_eq("stopped_updates", c, 0);

    // Zero setpoint still pulses update with duty 0
    @(negedge clk);
    kp = 8'd16; ki = 8'd16; setpoint = 8'd0; freq = 8'd50;
    enable = 1'b1;
    wait_update(lat);
    check_eq("sp0_latency", lat, 102);
    check_eq("sp0_duty", duty, 0);
    check_eq("sp0_sat", saturated, 0);
    check_eq("sp0_integ", dut.integ, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
